// File: rtl/up_down_monitor_pkg.sv
// Shared types and default widths for the up/down counter monitor.
// Optional feature macro used by this block: UP_DOWN_MONITOR_STALL_ERR_EN.
package up_down_monitor_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    PRIMED,
    UP,
    DOWN
  } state_t;

  localparam int DEFAULT_CW = 4;
  localparam int DEFAULT_SW = 8;

endpackage

// File: rtl/up_down_monitor_if.sv
// Sample/status bundle of the up/down counter monitor, with producer and monitor views.
interface up_down_monitor_if
  import up_down_monitor_pkg::*;
#(
  parameter int CW = DEFAULT_CW,
  parameter int SW = DEFAULT_SW
);

  logic          sample_valid;
  logic [CW-1:0] count_in;
  logic          locked;
  logic          dir;
  logic          wrap_pulse;
  logic          rev_pulse;
  logic          step_err;
  logic [SW-1:0] wrap_count;
  logic [SW-1:0] err_count;

  modport master (
    output sample_valid, count_in,
    input  locked, dir, wrap_pulse, rev_pulse, step_err, wrap_count, err_count
  );

  modport slave (
    input  sample_valid, count_in,
    output locked, dir, wrap_pulse, rev_pulse, step_err, wrap_count, err_count
  );

endinterface

// File: rtl/up_down_monitor_sat_counter.sv
// W-bit incrementer that sticks at all-ones; reset clears it synchronously.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/up_down_monitor.sv
// Watches an up/down counter, tracks its direction and flags wraps, reversals and bad steps.
// Define UP_DOWN_MONITOR_STALL_ERR_EN to treat a repeated value (delta 0) as a step error.
module up_down_monitor
  import up_down_monitor_pkg::*;
#(
  parameter int CW = DEFAULT_CW,
  parameter int SW = DEFAULT_SW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_valid,
  input  logic [CW-1:0] count_in,
  output logic          locked,
  output logic          dir,
  output logic          wrap_pulse,
  output logic          rev_pulse,
  output logic          step_err,
  output logic [SW-1:0] wrap_count,
  output logic [SW-1:0] err_count
);

  localparam logic [CW-1:0] STEP_ONE = CW'(1);
  localparam logic [CW-1:0] ALL_ONES = '1;
  localparam logic [CW-1:0] ZERO     = '0;

  state_t        state;
  logic [CW-1:0] prev;
  logic [CW-1:0] delta;
  logic          active;
  logic          step_up;
  logic          step_down;
  logic          illegal;
  logic          wrap_evt;

  // Classify the incoming sample against the held one; only meaningful once primed.
  always_comb begin
    delta     = count_in - prev;
    active    = sample_valid && (state != EMPTY);
    step_up   = active && (delta == STEP_ONE);
    step_down = active && (delta == ALL_ONES);
`ifdef UP_DOWN_MONITOR_STALL_ERR_EN
    illegal   = active && !step_up && !step_down;
`else
    illegal   = active && !step_up && !step_down && (delta != ZERO);
`endif
    wrap_evt  = (step_up && (prev == ALL_ONES)) || (step_down && (prev == ZERO));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      prev       <= '0;
      dir        <= 1'b0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      rev_pulse  <= 1'b0;
      step_err   <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      rev_pulse  <= 1'b0;
      step_err   <= 1'b0;
      if (sample_valid) begin
        prev <= count_in;
        if (state == EMPTY) begin
          state <= PRIMED;
        end else if (step_up) begin
          state      <= UP;
          locked     <= 1'b1;
          dir        <= 1'b0;
          rev_pulse  <= (state == DOWN);
          wrap_pulse <= wrap_evt;
        end else if (step_down) begin
          state      <= DOWN;
          locked     <= 1'b1;
          dir        <= 1'b1;
          rev_pulse  <= (state == UP);
          wrap_pulse <= wrap_evt;
        end else if (illegal) begin
          state    <= PRIMED;
          locked   <= 1'b0;
          step_err <= 1'b1;
        end
      end
    end
  end

  sat_counter #(.W(SW)) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap_evt),
    .count (wrap_count)
  );

  sat_counter #(.W(SW)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (illegal),
    .count (err_count)
  );

endmodule

// File: tb/tb_up_down_monitor.sv
// Directed scoreboard bench for up_down_monitor; honours UP_DOWN_MONITOR_STALL_ERR_EN if defined.
module tb_up_down_monitor;
  import up_down_monitor_pkg::*;

  localparam int CW  = DEFAULT_CW;
  localparam int SW  = DEFAULT_SW;
  localparam int M   = 1 << CW;
  localparam int SAT = (1 << SW) - 1;
`ifdef UP_DOWN_MONITOR_STALL_ERR_EN
  localparam bit STALL_IS_ERR = 1'b1;
`else
  localparam bit STALL_IS_ERR = 1'b0;
`endif

  typedef struct {
    logic locked;
    logic dir;
    logic wrap;
    logic rev;
    logic err;
    int   wrap_cnt;
    int   err_cnt;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  up_down_monitor_if #(.CW(CW), .SW(SW)) bus ();

  up_down_monitor #(.CW(CW), .SW(SW)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (bus.sample_valid),
    .count_in     (bus.count_in),
    .locked       (bus.locked),
    .dir          (bus.dir),
    .wrap_pulse   (bus.wrap_pulse),
    .rev_pulse    (bus.rev_pulse),
    .step_err     (bus.step_err),
    .wrap_count   (bus.wrap_count),
    .err_count    (bus.err_count)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: 0 = empty, 1 = primed, 2 = going up, 3 = going down
  int m_state = 0;
  int m_prev  = 0;
  bit m_dir   = 1'b0;
  int m_wc    = 0;
  int m_ec    = 0;

  task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pushModel(input bit w, input bit r, input bit e);
    exp_t x;
    x.locked   = (m_state >= 2);
    x.dir      = m_dir;
    x.wrap     = w;
    x.rev      = r;
    x.err      = e;
    x.wrap_cnt = m_wc;
    x.err_cnt  = m_ec;
    exp_q.push_back(x);
  endtask

  task automatic modelSample(input bit valid, input int val);
    int d;
    bit w, r, e;
    w = 1'b0; r = 1'b0; e = 1'b0;
    if (valid) begin
      if (m_state == 0) begin
        m_state = 1;
      end else begin
        d = (val - m_prev + M) % M;
        if (d == 1) begin
          w = (m_prev == M - 1);
          r = (m_state == 3);
          m_state = 2;
          m_dir = 1'b0;
        end else if (d == M - 1) begin
          w = (m_prev == 0);
          r = (m_state == 2);
          m_state = 3;
          m_dir = 1'b1;
        end else if (d == 0 && !STALL_IS_ERR) begin
          // repeated value: nothing changes
        end else begin
          e = 1'b1;
          m_state = 1;
        end
        if (w && m_wc < SAT) m_wc++;
        if (e && m_ec < SAT) m_ec++;
      end
      m_prev = val;
    end
    pushModel(w, r, e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t x;
    compared++;
    assert (exp_q.size() > 0) else begin
      mismatched++;
      $error("[TB] FAIL %s_queue: observed empty expected entry", tag);
      return;
    end
    x = exp_q.pop_front();
    checkField({tag, "_locked"},     bus.locked,     x.locked);
    checkField({tag, "_dir"},        bus.dir,        x.dir);
    checkField({tag, "_wrap_pulse"}, bus.wrap_pulse, x.wrap);
    checkField({tag, "_rev_pulse"},  bus.rev_pulse,  x.rev);
    checkField({tag, "_step_err"},   bus.step_err,   x.err);
    checkField({tag, "_wrap_count"}, bus.wrap_count, x.wrap_cnt);
    checkField({tag, "_err_count"},  bus.err_count,  x.err_cnt);
  endtask

  task automatic applyStimulus(input bit valid, input int val, input string tag);
    @(negedge clk);
    bus.sample_valid = valid;
    bus.count_in     = CW'(val);
    modelSample(valid, val);
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    checkOutput(tag);
  endtask

  // Reset is held together with a valid sample to show reset wins.
  task automatic applyReset(input string tag);
    @(negedge clk);
    reset            = 1'b1;
    bus.sample_valid = 1'b1;
    bus.count_in     = CW'(5);
    m_state = 0; m_prev = 0; m_dir = 1'b0; m_wc = 0; m_ec = 0;
    pushModel(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput(tag);
    @(negedge clk);
    reset            = 1'b0;
    bus.sample_valid = 1'b0;
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.count_in     = '0;
    $display("[TB] start, stall-as-error=%0d", STALL_IS_ERR);

    applyReset("reset0");
    applyStimulus(1, 3, "lock_3");
    applyStimulus(1, 4, "lock_4");
    applyStimulus(1, 5, "lock_5");
    checkField("lock_up_locked", bus.locked, 1);
    checkField("lock_up_dir", bus.dir, 0);
    applyStimulus(0, 9, "idle_hold");

    applyReset("reset1");
    applyStimulus(1, 14, "wrap_14");
    applyStimulus(1, 15, "wrap_15");
    applyStimulus(1, 0, "wrap_0");
    checkField("wrap_up_pulse", bus.wrap_pulse, 1);
    applyStimulus(1, 1, "wrap_1");
    checkField("wrap_up_count", bus.wrap_count, 1);

    applyReset("reset2");
    applyStimulus(1, 5, "rev_5");
    applyStimulus(1, 6, "rev_6");
    applyStimulus(1, 7, "rev_7");
    applyStimulus(1, 6, "rev_back6");
    checkField("rev_pulse_seen", bus.rev_pulse, 1);
    checkField("rev_dir_down", bus.dir, 1);
    applyStimulus(1, 7, "rev_again7");

    applyReset("reset3");
    applyStimulus(1, 1, "dwrap_1");
    applyStimulus(1, 0, "dwrap_0");
    applyStimulus(1, 15, "dwrap_15");
    applyStimulus(1, 14, "dwrap_14");

    applyReset("reset4");
    applyStimulus(1, 8, "err_8");
    applyStimulus(1, 9, "err_9");
    applyStimulus(1, 0, "err_0");
    checkField("err_step_pulse", bus.step_err, 1);
    checkField("err_unlocked", bus.locked, 0);
    applyStimulus(1, 1, "relock_1");
    checkField("relock_locked", bus.locked, 1);

    applyReset("reset5");
    applyStimulus(1, 2, "stall_2");
    applyStimulus(1, 3, "stall_3");
    applyStimulus(1, 3, "stall_3again");
    checkField("stall_step_err", bus.step_err, STALL_IS_ERR);

    applyReset("reset6");
    applyStimulus(1, 0, "sat_prime");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, (i % 2 == 0) ? 8 : 0, "sat_step");
    end
    checkField("sat_err_count", bus.err_count, SAT);
    applyStimulus(0, 3, "sat_hold");
    applyReset("sat_reset");
    applyStimulus(1, 7, "post_reset_prime");
    checkField("post_reset_no_err", bus.step_err, 0);
    checkField("post_reset_unlocked", bus.locked, 0);
    applyStimulus(1, 8, "post_reset_up");

    checkField("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/up_down_monitor.md
UP_DOWN_MONITOR -- requirements
Module: up_down_monitor

Interface
REQ-001 The module SHALL have parameter CW, default 4, giving the width of the observed count.
REQ-002 The module SHALL have parameter SW, default 8, giving the width of the statistics counters.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port sample_valid, input, 1 bit: count_in is sampled this cycle.
REQ-006 The module SHALL have port count_in, input, CW bits: the observed up/down counter value.
REQ-007 The module SHALL have port locked, output, 1 bit: direction is currently known.
REQ-008 The module SHALL have port dir, output, 1 bit: 0 = counting up, 1 = counting down.
REQ-009 The module SHALL have port wrap_pulse, output, 1 bit: one-cycle pulse on a legal 15->0 or 0->15 step.
REQ-010 The module SHALL have port rev_pulse, output, 1 bit: one-cycle pulse on a direction reversal.
REQ-011 The module SHALL have port step_err, output, 1 bit: one-cycle pulse on an illegal step.
REQ-012 The module SHALL have port wrap_count, output, SW bits: saturating count of wraps.
REQ-013 The module SHALL have port err_count, output, SW bits: saturating count of step errors.

Function
REQ-014 The module SHALL use the states EMPTY (no previous sample), PRIMED (previous sample held, direction unknown), UP and DOWN.
REQ-015 On a valid sample in EMPTY, the module SHALL store count_in as prev, go to PRIMED, and raise no pulse.
REQ-016 In all other states, the module SHALL compute delta = (count_in - prev) mod 2^CW on each valid sample, then update prev to count_in.
REQ-017 When delta = 1, the module SHALL go to UP; when delta = 2^CW-1, it SHALL go to DOWN.
REQ-018 When delta = 0, the module SHALL keep its state and raise no pulse.
REQ-019 For any other delta, the module SHALL raise step_err, increment err_count and go to PRIMED.
REQ-020 On a legal step UP->DOWN or DOWN->UP, the module SHALL raise rev_pulse; PRIMED->UP/DOWN SHALL NOT raise it.
REQ-021 The module SHALL raise wrap_pulse and increment wrap_count on any legal step prev=2^CW-1->0 (delta 1) or 0->2^CW-1 (delta 2^CW-1), in any state except EMPTY.
REQ-022 The module SHALL assert locked exactly in UP or DOWN; dir SHALL be 1 in DOWN and SHALL hold its last value otherwise.
REQ-023 All outputs SHALL be registered; a sample on edge N SHALL be reflected on outputs after edge N+1 (latency 1).
REQ-024 Pulses SHALL last exactly one cycle and SHALL be 0 in any cycle without sample_valid.
REQ-025 wrap_count and err_count SHALL saturate at 2^SW-1 and SHALL never roll over.
REQ-026 When sample_valid is low, the module SHALL hold all state.

Reset
REQ-027 When reset is high at an edge, the module SHALL go to EMPTY and clear prev, dir, locked, all pulses and both counters to 0, with priority over sample_valid.
REQ-028 A reset mid-tracking SHALL make the next valid sample prime only; it SHALL produce no error or wrap.

Configuration
REQ-029 With UP_DOWN_MONITOR_STALL_ERR_EN defined, delta = 0 outside EMPTY SHALL be treated as a step error per REQ-019.
REQ-030 Without UP_DOWN_MONITOR_STALL_ERR_EN, delta = 0 SHALL be handled per REQ-018.

Structure
REQ-031 Package up_down_monitor_pkg SHALL hold the state enum (EMPTY, PRIMED, UP, DOWN) and the default CW/SW constants.
REQ-032 Sub-module sat_counter (SW-bit saturating incrementer with synchronous clear) SHALL be instantiated twice, for wraps and errors.

Verification
REQ-033 Reset, then samples 3,4,5 -> locked=1 and dir=0 after the third sample; no pulses.
REQ-034 Samples 14,15,0,1 -> one wrap_pulse on the 15->0 step; wrap_count=1.
REQ-035 Samples 5,6,7,6 -> rev_pulse on 7->6; dir=1; locked stays 1.
REQ-036 Samples 8,9,0 -> step_err=1, err_count=1, locked=0; a following 1 relocks UP.
REQ-037 Samples 2,3,3 -> no error without the macro; step_err with UP_DOWN_MONITOR_STALL_ERR_EN defined.
REQ-038 Drive 300 illegal steps -> err_count=255 and holds; a reset mid-stream clears it, and the next sample only primes.
